// File: rtl/des_iter_ctrl.sv
// des_iter_ctrl: iterative DES block sequencer.
//
// Takes one 64-bit block per in_valid/in_ready handshake and applies the
// initial permutation. It then runs NUM_ROUNDS Feistel rounds, one per clock,
// through an external combinational f-function and key schedule. Last, it
// applies the final permutation and holds the result under
// out_valid/out_ready backpressure.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        input block valid
//   in_ready        controller can accept a block this cycle
//   in_data         64-bit input block (bit 63 = DES bit 1)
//   in_decrypt      0 = encrypt, 1 = decrypt, sampled with in_data
//   f_r             R half to the external f-function (0 outside ROUND)
//   f_subkey_idx    subkey number to the key schedule, 0 = K1 (0 outside ROUND)
//   f_out           f(f_r, K[f_subkey_idx]), combinational, same cycle
//   out_valid       result valid
//   out_ready       downstream accepts the result
//   out_data        64-bit result (bit 63 = DES bit 1)
//   busy            high in ROUND or DONE
//
// state | meaning
// IDLE  | waiting for a block, in_ready = 1
// ROUND | one Feistel round per cycle, rnd = 0 .. NUM_ROUNDS-1
// DONE  | result held on out_data until out_ready

module des_iter_ctrl #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_decrypt,
    output logic [31:0] f_r,
    output logic [3:0]  f_subkey_idx,
    input  logic [31:0] f_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] RND_LAST = 4'(NUM_ROUNDS - 1);

    // Standard DES tables: output bit i (1-based, MSB first) takes input bit TAB[i].
    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    function automatic logic [63:0] ip_perm(input logic [63:0] din);
        logic [63:0] dout;
        dout = '0;
        for (int i = 0; i < 64; i++)
            dout[6'(63 - i)] = din[6'(64 - IP_TAB[i])];
        return dout;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] din);
        logic [63:0] dout;
        dout = '0;
        for (int i = 0; i < 64; i++)
            dout[6'(63 - i)] = din[6'(64 - FP_TAB[i])];
        return dout;
    endfunction

    logic [1:0]  state;
    logic [31:0] l_half;
    logic [31:0] r_half;
    logic [3:0]  rnd;
    logic        dec;

    logic        load;
    logic [63:0] ip_blk;
    logic [31:0] r_next;

    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign load     = in_valid && in_ready;
    assign busy     = (state == S_ROUND) || (state == S_DONE);
    assign ip_blk   = ip_perm(in_data);
    assign r_next   = l_half ^ f_out;

    // Outputs to the shared datapath are parked at zero outside ROUND.
    assign f_r          = (state == S_ROUND) ? r_half : 32'd0;
    assign f_subkey_idx = (state == S_ROUND) ? (dec ? (RND_LAST - rnd) : rnd) : 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            l_half    <= '0;
            r_half    <= '0;
            rnd       <= '0;
            dec       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        {l_half, r_half} <= ip_blk;
                        dec              <= in_decrypt;
                        rnd              <= '0;
                        state            <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    l_half <= r_half;
                    r_half <= r_next;
                    if (rnd == RND_LAST) begin
                        // Preoutput is R16||L16: the last round's halves, unswapped.
                        out_data  <= fp_perm({r_next, r_half});
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (load) begin
                            {l_half, r_half} <= ip_blk;
                            dec              <= in_decrypt;
                            rnd              <= '0;
                            state            <= S_ROUND;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_iter_ctrl.sv
// tb_des_iter_ctrl: directed bench for des_iter_ctrl.
// The bench supplies the DES f-function and key schedule for key
// 133457799BBCDFF1. Expected results are the published vectors:
// 0123456789ABCDEF encrypts to 85E813540F0AB405.

module tb_des_iter_ctrl;

    localparam logic [63:0] KEY = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] PT  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] CT  = 64'h85E8_1354_0F0A_B405;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_decrypt;
    logic [31:0] f_r;
    logic [3:0]  f_subkey_idx;
    logic [31:0] f_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [47:0] subkey [16];

    des_iter_ctrl #(.NUM_ROUNDS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_decrypt   (in_decrypt),
        .f_r          (f_r),
        .f_subkey_idx (f_subkey_idx),
        .f_out        (f_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  b;
        int          row;
        int          col;
        e = '0;
        s = '0;
        p = '0;
        for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_T[i])];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            b   = e[6'(47 - 6 * j) -: 6];
            row = int'({b[5], b[0]});
            col = int'(b[4:1]);
            s[5'(31 - 4 * j) -: 4] = 4'(SBOX[j][row * 16 + col]);
        end
        for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_T[i])];
        return p;
    endfunction

    task automatic build_subkeys(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] sk;
        cd = '0;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1_T[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            sk = '0;
            for (int i = 0; i < 48; i++) sk[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
            subkey[r] = sk;
        end
    endtask

    always_comb f_out = des_f(f_r, subkey[f_subkey_idx]);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the controller ready; returns at the negedge after acceptance.
    task automatic send(input logic [63:0] data, input logic dec);
        in_valid   = 1'b1;
        in_data    = data;
        in_decrypt = dec;
        #1;
        chk("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Steps through ROUND from rnd = 0 until out_valid, checking the subkey order.
    // With poke set, a foreign block is offered at round 5 and must be refused.
    task automatic wait_result(input logic dec, input logic poke, output int n);
        logic seq_ok;
        seq_ok = 1'b1;
        n      = 0;
        while (!out_valid && n < 40) begin
            if (f_subkey_idx !== (dec ? 4'(15 - n) : 4'(n))) seq_ok = 1'b0;
            if (poke && n == 5) begin
                in_valid   = 1'b1;
                in_data    = 64'hFFFF_0000_1234_5678;
                in_decrypt = 1'b1;
                #1;
                chk("busy_in_ready", in_ready, 0);
            end
            if (poke && n == 6) in_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        chk(dec ? "subkey_seq_dec" : "subkey_seq_enc", seq_ok, 1);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pop_valid", out_valid, 0);
        chk("pop_in_ready", in_ready, 1);
    endtask

    int          n;
    logic        ok;
    logic [63:0] exp_s [5];

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_decrypt = 1'b0;
        out_ready  = 1'b0;
        build_subkeys(KEY);
        repeat (2) @(negedge clk);

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_f_r", f_r, 0);
        chk("rst_subkey_idx", f_subkey_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer encrypt with first-round observation
        send(PT, 1'b0);
        chk("first_f_r", f_r, 64'hF0AA_F0AA);
        chk("first_idx", f_subkey_idx, 0);
        chk("round_busy", busy, 1);
        chk("round_in_ready", in_ready, 0);
        wait_result(1'b0, 1'b0, n);
        chk("enc_latency", n, 16);
        chk("enc_data", out_data, CT);
        chk("done_f_r", f_r, 0);

        // Backpressure: ten stalled cycles, then back-to-back decrypt handoff
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_data !== CT || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
        end
        chk("stall_stable", ok, 1);
        out_ready = 1'b1;
        send(CT, 1'b1);
        out_ready = 1'b0;
        chk("handoff_valid", out_valid, 0);
        chk("handoff_busy", busy, 1);
        wait_result(1'b1, 1'b0, n);
        chk("dec_latency", n, 16);
        chk("dec_data", out_data, PT);
        pop();

        // A block offered mid-ROUND is ignored
        send(PT, 1'b0);
        wait_result(1'b0, 1'b1, n);
        chk("poke_latency", n, 16);
        chk("poke_data", out_data, CT);
        pop();

        // Asynchronous reset at round 7
        send(PT, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_f_r", f_r, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(PT, 1'b0);
        wait_result(1'b0, 1'b0, n);
        chk("post_rst_data", out_data, CT);
        pop();

        // Streaming: five blocks back-to-back; decrypts interleaved so order is visible
        for (int k = 0; k < 5; k++) exp_s[k] = (k % 2 == 1) ? PT : CT;
        out_ready = 1'b1;
        fork
            begin : drv
                int guard;
                logic acc;
                for (int k = 0; k < 5; k++) begin
                    in_valid   = 1'b1;
                    in_data    = (k % 2 == 1) ? CT : PT;
                    in_decrypt = (k % 2 == 1);
                    acc        = 1'b0;
                    guard      = 0;
                    while (!acc && guard < 100) begin
                        #1;
                        acc = in_ready;
                        @(negedge clk);
                        guard++;
                    end
                end
                in_valid = 1'b0;
            end
            begin : mon
                int got;
                int last;
                got  = 0;
                last = 0;
                for (int cyc = 0; cyc < 5 * 17 + 30; cyc++) begin
                    @(negedge clk);
                    #2;
                    if (out_valid) begin
                        if (got < 5) chk("stream_data", out_data, exp_s[got]);
                        if (got > 0) chk("stream_gap", cyc - last, 17);
                        last = cyc;
                        got++;
                    end
                end
                chk("stream_count", got, 5);
            end
        join
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
